paddle_widget: RTL and testbench

PADDLE_WIDGET -- requirements
Module: paddle_widget

---
 rtl/paddle_widget.sv | 80 ++++++++
 tb/tb_paddle_widget.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/paddle_widget.sv
// paddle_widget: switch-driven vertical paddle sprite with per-frame ball-hit reporting.
module paddle_widget #(
  parameter logic [10:0] XPOS = 11'd40,
  parameter logic [10:0] PW = 11'd10,
  parameter logic [10:0] PH = 11'd80,
  parameter logic [10:0] STEP = 11'd4,
  parameter logic [10:0] YMAX = 11'd480,
  parameter logic [3:0] RED_C = 4'd15,
  parameter logic [3:0] GREEN_C = 4'd15,
  parameter logic [3:0] BLUE_C = 4'd15
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic        enable,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        HBlank,
  input  logic        VBlank,
  input  logic        moveUp,
  input  logic        moveDown,
  input  logic        ballYes,
  output logic        yes,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hit,
  output logic [7:0]  hitCount
);
  localparam logic [10:0] Y0 = (YMAX - PH) >> 1;
  logic [1:0] up_s, dn_s;
  logic up_u, up_d, vb_q, vbr, pin, hit_f;
  logic [10:0] pos_y, disp_y, nxt_y;
  logic [11:0] pos_w, disp_w, x_w, y_w;
  assign up_u = up_s[1];
  assign up_d = dn_s[1];
  assign vbr = VBlank & ~vb_q;
  assign pos_w = {1'b0, pos_y};
  assign disp_w = {1'b0, disp_y};
  assign x_w = {1'b0, X};
  assign y_w = {1'b0, Y};
  // 12-bit compares keep pos+PH+STEP and edge sums from wrapping
  always_comb begin
    nxt_y = pos_y;
    if (up_u && !up_d)
      nxt_y = (pos_w >= {1'b0, STEP}) ? pos_y - STEP : '0;
    else if (up_d && !up_u)
      nxt_y = (pos_w + {1'b0, PH} + {1'b0, STEP} <= {1'b0, YMAX}) ? pos_y + STEP : YMAX - PH;
  end
  assign pin = (x_w >= {1'b0, XPOS}) && (x_w <= {1'b0, XPOS} + {1'b0, PW} - 12'd1) &&
               (y_w >= disp_w) && (y_w <= disp_w + {1'b0, PH} - 12'd1) && !HBlank && !VBlank;
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      up_s <= '0;
      dn_s <= '0;
      vb_q <= 1'b0;
      pos_y <= Y0;
      disp_y <= Y0;
      yes <= 1'b0;
      red <= '0;
      green <= '0;
      blue <= '0;
      hit <= 1'b0;
      hit_f <= 1'b0;
      hitCount <= '0;
    end else begin
      up_s <= {up_s[0], moveUp};
      dn_s <= {dn_s[0], moveDown};
      vb_q <= VBlank;
      if (enable) pos_y <= nxt_y;
      if (vbr) disp_y <= pos_y;
      yes <= pin;
      red <= pin ? RED_C : '0;
      green <= pin ? GREEN_C : '0;
      blue <= pin ? BLUE_C : '0;
      hit <= vbr & hit_f;
      if (vbr && hit_f && hitCount != 8'hff) hitCount <= hitCount + 8'd1;
      hit_f <= vbr ? 1'b0 : (hit_f | (pin & ballYes));
    end
  end
endmodule

// File: tb/tb_paddle_widget.sv
// tb_paddle_widget: vector table, corner sequences and random run against an arithmetic model.
module tb_paddle_widget;
  localparam int XP = 40, PWD = 10, PHT = 80, ST = 4, YM = 480, MID = (YM - PHT) / 2;
  logic clk = 0, rst, en, hb, vb, up, dn, ball;
  logic [10:0] x, y;
  logic yes, hit;
  logic [3:0] red, green, blue;
  logic [7:0] cnt;
  int checks = 0, failures = 0;
  int m_pos, m_disp, m_yes, m_hit, m_hitf, m_cnt, m_vb;
  int up_q[$], dn_q[$];
  typedef struct {int x; int y; int hb; int vb; int yes;} vec_t;
  vec_t tbl[10];

  paddle_widget dut (.CLK_100MHz(clk), .Reset(rst), .enable(en), .X(x), .Y(y), .HBlank(hb),
    .VBlank(vb), .moveUp(up), .moveDown(dn), .ballYes(ball), .yes(yes), .red(red),
    .green(green), .blue(blue), .hit(hit), .hitCount(cnt));

  always #5 clk = ~clk;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Reference: switches seen two edges late, position clamped to [0, YM-PHT],
  // displayed row latched at frame start, hits accumulated per frame.
  task automatic model();
    int uu, ud, vbr, pin, np;
    if (rst) begin
      m_pos = MID; m_disp = MID; m_yes = 0; m_hit = 0; m_hitf = 0; m_cnt = 0; m_vb = 0;
      up_q = '{0, 0}; dn_q = '{0, 0};
      return;
    end
    uu = up_q.pop_front(); ud = dn_q.pop_front();
    up_q.push_back(int'(up)); dn_q.push_back(int'(dn));
    vbr = (vb && !m_vb) ? 1 : 0;
    pin = (x >= XP && x < XP + PWD && y >= m_disp && y < m_disp + PHT && !hb && !vb) ? 1 : 0;
    np = m_pos;
    if (en && uu && !ud) np = (m_pos - ST < 0) ? 0 : m_pos - ST;
    if (en && ud && !uu) np = (m_pos + ST > YM - PHT) ? YM - PHT : m_pos + ST;
    if (vbr) m_disp = m_pos;
    m_pos = np;
    m_hit = vbr && m_hitf;
    if (m_hit && m_cnt < 255) m_cnt++;
    m_hitf = vbr ? 0 : (m_hitf || (pin && ball));
    m_yes = pin;
    m_vb = vb;
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("yes", yes, m_yes);
    chk("red", red, m_yes ? 15 : 0);
    chk("green", green, m_yes ? 15 : 0);
    chk("blue", blue, m_yes ? 15 : 0);
    chk("hit", hit, m_hit);
    chk("hitCount", cnt, m_cnt);
    chk("posY", dut.pos_y, m_pos);
    chk("dispY", dut.disp_y, m_disp);
  endtask

  task automatic idle();
    en = 0; x = 0; y = 0; hb = 0; vb = 0; ball = 0; up = 0; dn = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); step(); rst = 0;
  endtask

  task automatic vpulse();
    vb = 1; step(); vb = 0; step();
  endtask

  initial begin
    tbl[0] = '{45, 250, 0, 0, 1};
    tbl[1] = '{50, 250, 0, 0, 0};
    tbl[2] = '{40, 200, 0, 0, 1};
    tbl[3] = '{49, 279, 0, 0, 1};
    tbl[4] = '{39, 250, 0, 0, 0};
    tbl[5] = '{45, 199, 0, 0, 0};
    tbl[6] = '{45, 280, 0, 0, 0};
    tbl[7] = '{45, 250, 1, 0, 0};
    tbl[8] = '{45, 250, 0, 1, 0};
    tbl[9] = '{44, 240, 0, 0, 1};
    do_reset();
    chk("rst_yes", yes, 0); chk("rst_hit", hit, 0); chk("rst_cnt", cnt, 0);
    chk("rst_pos", dut.pos_y, 200); chk("rst_disp", dut.disp_y, 200);
    foreach (tbl[i]) begin
      x = tbl[i].x; y = tbl[i].y; hb = tbl[i].hb; vb = tbl[i].vb;
      step();
      chk("tbl_yes", yes, tbl[i].yes);
      chk("tbl_red", red, tbl[i].yes ? 15 : 0);
    end
    // upward walk to the top edge, frames interleaved
    do_reset();
    up = 1;
    for (int i = 0; i < 60; i++) begin
      en = 1; step(); en = 0; step();
      if (i % 10 == 9) vpulse();
    end
    chk("up_floor", dut.pos_y, 0);
    vpulse();
    chk("up_disp", dut.disp_y, 0);
    // downward walk to the bottom edge, then both switches held
    up = 0; dn = 1;
    for (int i = 0; i < 110; i++) begin
      en = 1; step(); en = 0;
    end
    chk("dn_ceiling", dut.pos_y, 400);
    up = 1; step(); step();
    for (int i = 0; i < 5; i++) begin
      en = 1; step(); en = 0;
    end
    chk("both_hold", dut.pos_y, 400);
    // single-pixel overlap then frame boundary
    do_reset();
    x = 45; y = 250; ball = 1; step();
    ball = 0; x = 0; step();
    vb = 1; step();
    chk("hit_pulse", hit, 1); chk("hit_cnt1", cnt, 1);
    step();
    chk("hit_once", hit, 0);
    vb = 0; step(); step();
    vb = 1; step();
    chk("hit_none", hit, 0); chk("hit_cnt_keep", cnt, 1);
    // saturation of the hit counter
    do_reset();
    for (int i = 0; i < 260; i++) begin
      vb = 0; x = 45; y = 250; ball = 1; step();
      vb = 1; ball = 0; step();
    end
    chk("sat_hit", hit, 1); chk("sat_cnt", cnt, 255);
    // pending hit discarded by reset
    do_reset();
    x = 45; y = 250; ball = 1; step();
    ball = 0; rst = 1; vb = 1; step();
    chk("rd_hit", hit, 0); chk("rd_yes", yes, 0); chk("rd_red", red, 0);
    chk("rd_pos", dut.pos_y, 200); chk("rd_disp", dut.disp_y, 200);
    rst = 0; step();
    chk("rd_nohit", hit, 0); chk("rd_cnt", cnt, 0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) vb = ~vb;
      hb = ($urandom_range(0, 7) == 0);
      x = 11'($urandom_range(30, 60));
      y = 11'($urandom_range(0, 490));
      ball = $urandom_range(0, 1);
      if ($urandom_range(0, 40) == 0) up = $urandom_range(0, 1);
      if ($urandom_range(0, 40) == 0) dn = $urandom_range(0, 1);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
